// File: rtl/booth_mul_iter_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
// Operands are widened to 34 bits so that MULT and MULTU share one datapath.
package booth_mul_iter_pkg;

  typedef enum logic [1:0] {
    MUL_FREE = 2'b00,
    MUL_ON   = 2'b01,
    MUL_END  = 2'b10
  } mul_state_t;

  localparam int MUL_ITER_NUM = 17;
  localparam int CNT_W        = 5;
  localparam int OPND_W       = 34;
  localparam int PP_W         = OPND_W + 1;
  localparam int ACC_W        = PP_W + OPND_W + 1;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Sign- or zero-extend a 32-bit operand to the shared 34-bit width.
  function automatic logic [OPND_W-1:0] ext34(input logic is_signed, input logic [31:0] v);
    return {{2{is_signed & v[31]}}, v};
  endfunction

endpackage

// File: rtl/booth_mul_iter_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to 0, +-A or +-2A.
module booth_r4_enc
  import booth_mul_iter_pkg::*;
(
  input  logic [2:0]        digit,
  input  logic [OPND_W-1:0] a,
  output logic [PP_W-1:0]   pp
);

  logic [PP_W-1:0] a_x1;
  logic [PP_W-1:0] a_x2;

  assign a_x1 = {a[OPND_W-1], a};
  assign a_x2 = {a, 1'b0};

  always_comb begin
    pp = '0;
    unique case (digit)
      3'b001, 3'b010: pp = a_x1;
      3'b011:         pp = a_x2;
      3'b100:         pp = -a_x2;
      3'b101, 3'b110: pp = -a_x1;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier for MULT/MULTU, 17 steps per product,
// using the same start/ready/annul handshake as the iterative divider.
module booth_mul_iter
  import booth_mul_iter_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_mul_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  mul_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [OPND_W-1:0] a_reg, a_next;
  logic [63:0]       result_reg, result_next;
  logic              ready_reg, ready_next;

  logic [PP_W-1:0]   pp;
  logic [PP_W-1:0]   upper_sum;
  logic [ACC_W-1:0]  stepped;
  logic              zero_opnd;

  booth_r4_enc u_enc (
    .digit (acc_reg[2:0]),
    .a     (a_reg),
    .pp    (pp)
  );

  // Accumulator layout: {partial sum (35) | multiplier (34) | guard bit}.
  assign upper_sum = acc_reg[ACC_W-1 -: PP_W] + pp;
  assign stepped   = ACC_W'($signed({upper_sum, acc_reg[ACC_W-PP_W-1:0]}) >>> 2);
  assign zero_opnd = (opdata1_i == ZERO_WORD) || (opdata2_i == ZERO_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= MUL_FREE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      a_reg      <= '0;
      result_reg <= '0;
      ready_reg  <= DIV_RESULT_NOT_READY;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      a_reg      <= a_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    a_next      = a_reg;
    result_next = result_reg;
    ready_next  = ready_reg;

    unique case (state_reg)
      MUL_FREE: begin
        ready_next  = DIV_RESULT_NOT_READY;
        result_next = '0;
        if (start_i == DIV_START && !annul_i) begin
          if (ZERO_SKIP && zero_opnd) begin
            state_next = MUL_END;
            ready_next = DIV_RESULT_READY;
          end else begin
            a_next     = ext34(signed_mul_i, opdata1_i);
            acc_next   = {{PP_W{1'b0}}, ext34(signed_mul_i, opdata2_i), 1'b0};
            cnt_next   = '0;
            state_next = MUL_ON;
          end
        end
      end

      MUL_ON: begin
        if (annul_i || start_i == DIV_STOP) begin
          state_next  = MUL_FREE;
          ready_next  = DIV_RESULT_NOT_READY;
          result_next = '0;
          acc_next    = '0;
          cnt_next    = '0;
        end else begin
          acc_next = stepped;
          cnt_next = cnt_reg + 1'b1;
          // After the final shift the product sits just above the guard bit.
          if (cnt_reg == CNT_W'(MUL_ITER_NUM - 1)) begin
            state_next  = MUL_END;
            ready_next  = DIV_RESULT_READY;
            result_next = stepped[64:1];
          end
        end
      end

      MUL_END: begin
        if (annul_i || start_i == DIV_STOP) begin
          state_next  = MUL_FREE;
          ready_next  = DIV_RESULT_NOT_READY;
          result_next = '0;
        end
      end

      default: begin
        state_next  = MUL_FREE;
        ready_next  = DIV_RESULT_NOT_READY;
        result_next = '0;
      end
    endcase
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Directed bench for booth_mul_iter: vector table plus reset/abort/back-to-back sequences.
module tb_booth_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_mul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  booth_mul_iter #(.ZERO_SKIP(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_mul_i (signed_mul_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Counts negedges until ready_o rises (bounded), then checks latency and product.
  task automatic wait_ready(input string name, input int exp_lat, input logic [63:0] exp);
    int k;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (ready_o === 1'b1) break;
    end
    chk({name, " latency"}, 64'(k), 64'(exp_lat));
    chk({name, " result"}, result_o, exp);
    $display("op %s: result=%h ready=%b cycles=%0d", name, result_o, ready_o, k);
  endtask

  task automatic drop_start(input string name);
    start_i = 1'b0;
    @(negedge clk);
    chk({name, " ready drop"}, 64'(ready_o), 64'd0);
    chk({name, " result clear"}, result_o, 64'd0);
  endtask

  task automatic do_op(input string name, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] prod, input int lat);
    signed_mul_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    wait_ready(name, lat, prod);
    drop_start(name);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd3,         32'd5,         64'h0000_0000_0000_000F, 18};
    vecs[1]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFF9, 18};
    vecs[2]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 18};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 18};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0,                   1};
    vecs[5]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 18};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 18};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000, 18};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 18};
    vecs[9]  = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 18};
    vecs[10] = '{1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 64'h0,                   1};
    vecs[11] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 18};

    rst          = 1'b1;
    signed_mul_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat);
    end

    // Reset in the middle of an operation, with start still held high.
    signed_mul_i = 1'b0;
    opdata1_i    = 32'h0000_1234;
    opdata2_i    = 32'h0000_5678;
    start_i      = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst pre ready", 64'(ready_o), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst ready", 64'(ready_o), 64'd0);
    chk("midrst result", result_o, 64'd0);
    rst       = 1'b0;
    opdata1_i = 32'd3;
    opdata2_i = 32'd5;
    wait_ready("after_rst", 18, 64'h0000_0000_0000_000F);
    drop_start("after_rst");

    // Annul at cycle 5, held together with start: annul must win in FREE.
    signed_mul_i = 1'b1;
    opdata1_i    = 32'h0000_0777;
    opdata2_i    = 32'h0000_0333;
    start_i      = 1'b1;
    repeat (5) @(negedge clk);
    annul_i   = 1'b1;
    opdata1_i = 32'h0001_0000;
    opdata2_i = 32'h0001_0000;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("annul hold%0d ready", j), 64'(ready_o), 64'd0);
    end
    annul_i = 1'b0;
    wait_ready("restart", 18, 64'h0000_0001_0000_0000);

    // Hold start through END: result stays put even though operands change.
    opdata1_i = 32'hAAAA_AAAA;
    opdata2_i = 32'h5555_5555;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("hold%0d ready", j), 64'(ready_o), 64'd1);
      chk($sformatf("hold%0d result", j), result_o, 64'h0000_0001_0000_0000);
    end
    drop_start("hold");

    // Back-to-back with new operands; operands disturbed after acceptance.
    signed_mul_i = 1'b1;
    opdata1_i    = 32'hFFFF_FFFD;
    opdata2_i    = 32'h0000_0100;
    start_i      = 1'b1;
    @(negedge clk);
    chk("b2b early ready", 64'(ready_o), 64'd0);
    opdata1_i = 32'h0000_0009;
    opdata2_i = 32'h0000_0009;
    wait_ready("b2b", 17, 64'hFFFF_FFFF_FFFF_FD00);
    drop_start("b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
